// File: rtl/hsv_threshold_bbox_if.sv
// HSV pixel stream bundle: frame/line syncs, data enable and the H/S/V samples
// produced by the upstream colour-space stage.
interface hsv_threshold_bbox_if;
    logic       hsv_vs;
    logic       hsv_hs;
    logic       hsv_de;
    logic [8:0] hsv_h;
    logic [8:0] hsv_s;
    logic [7:0] hsv_v;

    modport master (
        output hsv_vs, hsv_hs, hsv_de, hsv_h, hsv_s, hsv_v
    );

    modport slave (
        input hsv_vs, hsv_hs, hsv_de, hsv_h, hsv_s, hsv_v
    );
endinterface

// File: rtl/hsv_threshold_bbox.sv
// HSV colour threshold producing a binary mask plus the per-frame bounding box
// of matched pixels. Define HSV_BBOX_PIXCNT_EN to add the matched-pixel counter.
module hsv_threshold_bbox #(
    parameter int COORD_W    = 11,
    parameter int MIN_PIXELS = 64
) (
    input  logic                   clk,
    input  logic                   reset_n,
    hsv_threshold_bbox_if.slave    hsv_in,
    input  logic [8:0]             h_min,
    input  logic [8:0]             h_max,
    input  logic [8:0]             s_min,
    input  logic [8:0]             s_max,
    input  logic [7:0]             v_min,
    input  logic [7:0]             v_max,
    output logic                   mask_vs,
    output logic                   mask_hs,
    output logic                   mask_de,
    output logic                   mask_bin,
    output logic [COORD_W-1:0]     box_x_min,
    output logic [COORD_W-1:0]     box_x_max,
    output logic [COORD_W-1:0]     box_y_min,
    output logic [COORD_W-1:0]     box_y_max,
    output logic                   box_found,
    output logic                   box_valid,
    output logic [20:0]            pixel_count
);

    localparam logic [COORD_W-1:0] COORD_MAX  = {COORD_W{1'b1}};
    localparam logic [COORD_W-1:0] COORD_ZERO = {COORD_W{1'b0}};
    localparam logic [COORD_W-1:0] COORD_ONE  = {{(COORD_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_WAIT_VS = 1'b0,
        ST_ACCUM   = 1'b1
    } state_t;

    function automatic logic in_range9(input logic [8:0] val,
                                       input logic [8:0] lo,
                                       input logic [8:0] hi);
        return (val >= lo) && (val <= hi);
    endfunction

    function automatic logic in_range8(input logic [7:0] val,
                                       input logic [7:0] lo,
                                       input logic [7:0] hi);
        return (val >= lo) && (val <= hi);
    endfunction

    // Hue is circular: lo > hi selects the band that wraps through 0.
    function automatic logic hue_match(input logic [8:0] hue,
                                       input logic [8:0] lo,
                                       input logic [8:0] hi);
        logic hit;
        if (lo <= hi) begin
            hit = (hue >= lo) && (hue <= hi);
        end else begin
            hit = (hue >= lo) || (hue <= hi);
        end
        return hit;
    endfunction

    // ---------------- threshold / mask stage ----------------
    logic [8:0] h_min_q, h_min_d, h_max_q, h_max_d;
    logic [8:0] s_min_q, s_min_d, s_max_q, s_max_d;
    logic [7:0] v_min_q, v_min_d, v_max_q, v_max_d;
    logic       mask_vs_q, mask_vs_d, mask_hs_q, mask_hs_d;
    logic       mask_de_q, mask_de_d, mask_bin_q, mask_bin_d;
    logic       in_vs_rise_s;

    assign in_vs_rise_s = hsv_in.hsv_vs & ~mask_vs_q;

    // Shadow thresholds follow the inputs only at frame start; the _d values
    // are also what the current pixel is compared against.
    always_comb begin
        h_min_d = h_min_q;
        h_max_d = h_max_q;
        s_min_d = s_min_q;
        s_max_d = s_max_q;
        v_min_d = v_min_q;
        v_max_d = v_max_q;
        if (in_vs_rise_s) begin
            h_min_d = h_min;
            h_max_d = h_max;
            s_min_d = s_min;
            s_max_d = s_max;
            v_min_d = v_min;
            v_max_d = v_max;
        end else begin
            h_min_d = h_min_q;
            h_max_d = h_max_q;
        end
        mask_vs_d  = hsv_in.hsv_vs;
        mask_hs_d  = hsv_in.hsv_hs;
        mask_de_d  = hsv_in.hsv_de;
        mask_bin_d = hsv_in.hsv_de
                   & hue_match(hsv_in.hsv_h, h_min_d, h_max_d)
                   & in_range9(hsv_in.hsv_s, s_min_d, s_max_d)
                   & in_range8(hsv_in.hsv_v, v_min_d, v_max_d);
    end

    // Mask pipeline and shadow threshold registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_min_q    <= 9'd0;
            h_max_q    <= 9'd0;
            s_min_q    <= 9'd0;
            s_max_q    <= 9'd0;
            v_min_q    <= 8'd0;
            v_max_q    <= 8'd0;
            mask_vs_q  <= 1'b0;
            mask_hs_q  <= 1'b0;
            mask_de_q  <= 1'b0;
            mask_bin_q <= 1'b0;
        end else begin
            h_min_q    <= h_min_d;
            h_max_q    <= h_max_d;
            s_min_q    <= s_min_d;
            s_max_q    <= s_max_d;
            v_min_q    <= v_min_d;
            v_max_q    <= v_max_d;
            mask_vs_q  <= mask_vs_d;
            mask_hs_q  <= mask_hs_d;
            mask_de_q  <= mask_de_d;
            mask_bin_q <= mask_bin_d;
        end
    end

    // ---------------- coordinate / bounding-box stage ----------------
    state_t             state_q, state_d;
    logic               mask_vs_prev_q, mask_de_prev_q;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic [COORD_W-1:0] rx_min_q, rx_min_d, rx_max_q, rx_max_d;
    logic [COORD_W-1:0] ry_min_q, ry_min_d, ry_max_q, ry_max_d;
    logic [COORD_W-1:0] box_x_min_q, box_x_min_d, box_x_max_q, box_x_max_d;
    logic [COORD_W-1:0] box_y_min_q, box_y_min_d, box_y_max_q, box_y_max_d;
    logic               box_found_q, box_found_d, box_valid_q, box_valid_d;
    logic               mask_vs_rise_s, mask_de_fall_s, accum_en_s, run_nz_s;
    logic [COORD_W-1:0] pix_x_s, pix_y_s;
`ifdef HSV_BBOX_PIXCNT_EN
    logic [20:0]        run_cnt_q, run_cnt_d;
    logic [20:0]        pixel_count_q, pixel_count_d;
`else
    logic               run_any_q, run_any_d;
`endif

    assign mask_vs_rise_s = mask_vs_q & ~mask_vs_prev_q;
    assign mask_de_fall_s = mask_de_prev_q & ~mask_de_q;
    assign accum_en_s     = (state_q == ST_ACCUM) || mask_vs_rise_s;
    assign pix_x_s        = x_q;
    // A pixel arriving with the frame-start edge belongs to row 0 of the new frame.
    assign pix_y_s        = mask_vs_rise_s ? COORD_ZERO : y_q;
`ifdef HSV_BBOX_PIXCNT_EN
    assign run_nz_s = (run_cnt_q != 21'd0);
`else
    assign run_nz_s = run_any_q;
`endif

    // Pixel coordinates, FSM and running/latched box computation.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        rx_min_d    = rx_min_q;
        rx_max_d    = rx_max_q;
        ry_min_d    = ry_min_q;
        ry_max_d    = ry_max_q;
        box_x_min_d = box_x_min_q;
        box_x_max_d = box_x_max_q;
        box_y_min_d = box_y_min_q;
        box_y_max_d = box_y_max_q;
        box_found_d = box_found_q;
        box_valid_d = 1'b0;
`ifdef HSV_BBOX_PIXCNT_EN
        run_cnt_d     = run_cnt_q;
        pixel_count_d = pixel_count_q;
`else
        run_any_d     = run_any_q;
`endif

        if (mask_de_q) begin
            x_d = (x_q == COORD_MAX) ? x_q : (x_q + COORD_ONE);
        end else begin
            x_d = COORD_ZERO;
        end

        if (mask_vs_rise_s) begin
            y_d = COORD_ZERO;
        end else if (mask_de_fall_s) begin
            y_d = (y_q == COORD_MAX) ? y_q : (y_q + COORD_ONE);
        end else begin
            y_d = y_q;
        end

        case (state_q)
            ST_WAIT_VS: state_d = mask_vs_rise_s ? ST_ACCUM : ST_WAIT_VS;
            ST_ACCUM:   state_d = ST_ACCUM;
            default:    state_d = ST_WAIT_VS;
        endcase

        // Frame boundary: publish the finished frame, then restart accumulation.
        if (mask_vs_rise_s && (state_q == ST_ACCUM)) begin
            box_valid_d = 1'b1;
            box_x_min_d = run_nz_s ? rx_min_q : COORD_ZERO;
            box_x_max_d = run_nz_s ? rx_max_q : COORD_ZERO;
            box_y_min_d = run_nz_s ? ry_min_q : COORD_ZERO;
            box_y_max_d = run_nz_s ? ry_max_q : COORD_ZERO;
`ifdef HSV_BBOX_PIXCNT_EN
            box_found_d   = (run_cnt_q >= 21'(MIN_PIXELS));
            pixel_count_d = run_cnt_q;
`else
            box_found_d   = run_any_q;
`endif
        end else begin
            box_valid_d = 1'b0;
        end

        if (mask_vs_rise_s) begin
            rx_min_d = COORD_MAX;
            rx_max_d = COORD_ZERO;
            ry_min_d = COORD_MAX;
            ry_max_d = COORD_ZERO;
`ifdef HSV_BBOX_PIXCNT_EN
            run_cnt_d = 21'd0;
`else
            run_any_d = 1'b0;
`endif
        end else begin
            rx_min_d = rx_min_q;
        end

        if (accum_en_s && mask_bin_q) begin
            rx_min_d = (pix_x_s < rx_min_d) ? pix_x_s : rx_min_d;
            rx_max_d = (pix_x_s > rx_max_d) ? pix_x_s : rx_max_d;
            ry_min_d = (pix_y_s < ry_min_d) ? pix_y_s : ry_min_d;
            ry_max_d = (pix_y_s > ry_max_d) ? pix_y_s : ry_max_d;
`ifdef HSV_BBOX_PIXCNT_EN
            run_cnt_d = (run_cnt_d == 21'h1F_FFFF) ? run_cnt_d : (run_cnt_d + 21'd1);
`else
            run_any_d = 1'b1;
`endif
        end else begin
            rx_max_d = rx_max_d;
        end
    end

    // Box-stage state, counters and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_WAIT_VS;
            mask_vs_prev_q <= 1'b0;
            mask_de_prev_q <= 1'b0;
            x_q            <= COORD_ZERO;
            y_q            <= COORD_ZERO;
            rx_min_q       <= COORD_MAX;
            rx_max_q       <= COORD_ZERO;
            ry_min_q       <= COORD_MAX;
            ry_max_q       <= COORD_ZERO;
            box_x_min_q    <= COORD_ZERO;
            box_x_max_q    <= COORD_ZERO;
            box_y_min_q    <= COORD_ZERO;
            box_y_max_q    <= COORD_ZERO;
            box_found_q    <= 1'b0;
            box_valid_q    <= 1'b0;
`ifdef HSV_BBOX_PIXCNT_EN
            run_cnt_q      <= 21'd0;
            pixel_count_q  <= 21'd0;
`else
            run_any_q      <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            mask_vs_prev_q <= mask_vs_q;
            mask_de_prev_q <= mask_de_q;
            x_q            <= x_d;
            y_q            <= y_d;
            rx_min_q       <= rx_min_d;
            rx_max_q       <= rx_max_d;
            ry_min_q       <= ry_min_d;
            ry_max_q       <= ry_max_d;
            box_x_min_q    <= box_x_min_d;
            box_x_max_q    <= box_x_max_d;
            box_y_min_q    <= box_y_min_d;
            box_y_max_q    <= box_y_max_d;
            box_found_q    <= box_found_d;
            box_valid_q    <= box_valid_d;
`ifdef HSV_BBOX_PIXCNT_EN
            run_cnt_q      <= run_cnt_d;
            pixel_count_q  <= pixel_count_d;
`else
            run_any_q      <= run_any_d;
`endif
        end
    end

    assign mask_vs   = mask_vs_q;
    assign mask_hs   = mask_hs_q;
    assign mask_de   = mask_de_q;
    assign mask_bin  = mask_bin_q;
    assign box_x_min = box_x_min_q;
    assign box_x_max = box_x_max_q;
    assign box_y_min = box_y_min_q;
    assign box_y_max = box_y_max_q;
    assign box_found = box_found_q;
    assign box_valid = box_valid_q;
`ifdef HSV_BBOX_PIXCNT_EN
    assign pixel_count = pixel_count_q;
`else
    assign pixel_count = 21'd0;
`endif

endmodule

// File: tb/tb_hsv_threshold_bbox.sv
// Directed bench for hsv_threshold_bbox: mask latency, hue wrap, bounding box,
// empty frame, mid-frame reset, threshold shadowing and frame-start coincidence.
module tb_hsv_threshold_bbox;

    localparam int CW   = 11;
    localparam int MINP = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [8:0]    h_min, h_max, s_min, s_max;
    logic [7:0]    v_min, v_max;
    logic          mask_vs, mask_hs, mask_de, mask_bin;
    logic [CW-1:0] box_x_min, box_x_max, box_y_min, box_y_max;
    logic          box_found, box_valid;
    logic [20:0]   pixel_count;

    int n_vec = 0;
    int n_err = 0;

    hsv_threshold_bbox_if hsv_bus ();

    hsv_threshold_bbox #(.COORD_W(CW), .MIN_PIXELS(MINP)) dut (
        .clk(clk), .reset_n(reset_n), .hsv_in(hsv_bus.slave),
        .h_min(h_min), .h_max(h_max), .s_min(s_min), .s_max(s_max),
        .v_min(v_min), .v_max(v_max),
        .mask_vs(mask_vs), .mask_hs(mask_hs), .mask_de(mask_de), .mask_bin(mask_bin),
        .box_x_min(box_x_min), .box_x_max(box_x_max),
        .box_y_min(box_y_min), .box_y_max(box_y_max),
        .box_found(box_found), .box_valid(box_valid), .pixel_count(pixel_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input logic de, input logic [8:0] h);
        hsv_bus.hsv_de = de;
        hsv_bus.hsv_hs = ~de;
        hsv_bus.hsv_h  = h;
        hsv_bus.hsv_s  = 9'd200;
        hsv_bus.hsv_v  = 8'd200;
    endtask

    task automatic vs_pulse(input logic exp_valid);
        hsv_bus.hsv_vs = 1'b1;
        pix(1'b0, 9'd0);
        cyc();
        cyc();
        chk("box_valid_pulse", {31'd0, box_valid}, {31'd0, exp_valid});
        hsv_bus.hsv_vs = 1'b0;
        cyc();
        chk("box_valid_end", {31'd0, box_valid}, 32'd0);
        repeat (3) cyc();
    endtask

    task automatic frame(input int x0, input int x1, input int y0, input int y1,
                         input int chg_line, input logic [8:0] nmin, input logic [8:0] nmax);
        for (int ln = 0; ln < 48; ln++) begin
            if (ln == chg_line) begin
                h_min = nmin;
                h_max = nmax;
            end
            for (int px = 0; px < 64; px++) begin
                pix(1'b1, (px >= x0 && px <= x1 && ln >= y0 && ln <= y1) ? 9'd120 : 9'd60);
                cyc();
            end
            pix(1'b0, 9'd0);
            repeat (4) cyc();
        end
    endtask

    task automatic check_box(input int x0, input int x1, input int y0, input int y1, input int cnt);
        int ex0, ex1, ey0, ey1, efound, ecnt;
        ex0 = (cnt > 0) ? x0 : 0;
        ex1 = (cnt > 0) ? x1 : 0;
        ey0 = (cnt > 0) ? y0 : 0;
        ey1 = (cnt > 0) ? y1 : 0;
`ifdef HSV_BBOX_PIXCNT_EN
        efound = (cnt >= MINP) ? 1 : 0;
        ecnt   = cnt;
`else
        efound = (cnt > 0) ? 1 : 0;
        ecnt   = 0;
`endif
        chk("box_x_min", {21'd0, box_x_min}, ex0);
        chk("box_x_max", {21'd0, box_x_max}, ex1);
        chk("box_y_min", {21'd0, box_y_min}, ey0);
        chk("box_y_max", {21'd0, box_y_max}, ey1);
        chk("box_found", {31'd0, box_found}, efound);
        chk("pixel_count", {11'd0, pixel_count}, ecnt);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_x_min"}, {21'd0, box_x_min}, 32'd0);
        chk({tag, "_x_max"}, {21'd0, box_x_max}, 32'd0);
        chk({tag, "_y_max"}, {21'd0, box_y_max}, 32'd0);
        chk({tag, "_found"}, {31'd0, box_found}, 32'd0);
        chk({tag, "_valid"}, {31'd0, box_valid}, 32'd0);
        chk({tag, "_mask_bin"}, {31'd0, mask_bin}, 32'd0);
        chk({tag, "_mask_de"}, {31'd0, mask_de}, 32'd0);
        chk({tag, "_pixcnt"}, {11'd0, pixel_count}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] hues [5];
        logic       hexp [5];
        hues = '{9'd350, 9'd0, 9'd15, 9'd21, 9'd339};
        hexp = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

        reset_n = 1'b0;
        hsv_bus.hsv_vs = 1'b0;
        pix(1'b0, 9'd0);
        h_min = 9'd100; h_max = 9'd140;
        s_min = 9'd50;  s_max = 9'd256;
        v_min = 8'd50;  v_max = 8'd255;
        repeat (3) cyc();
        check_all_zero("reset");
        reset_n = 1'b1;
        repeat (3) cyc();

        // First frame start after reset: no box yet.
        vs_pulse(1'b0);
        pix(1'b1, 9'd90);  cyc();
        chk("mask_h90", {31'd0, mask_bin}, 32'd0);
        pix(1'b1, 9'd120);
        chk("mask_latency_pre", {31'd0, mask_bin}, 32'd0);
        cyc();
        chk("mask_h120", {31'd0, mask_bin}, 32'd1);
        chk("mask_de_aligned", {31'd0, mask_de}, 32'd1);
        pix(1'b1, 9'd90);  cyc();
        chk("mask_h90_again", {31'd0, mask_bin}, 32'd0);
        pix(1'b0, 9'd0);
        repeat (4) cyc();

        // Hue wrap-around band 340..20.
        h_min = 9'd340; h_max = 9'd20;
        vs_pulse(1'b1);
        check_box(1, 1, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            pix(1'b1, hues[i]);
            cyc();
            chk($sformatf("hue_wrap_%0d", hues[i]), {31'd0, mask_bin}, {31'd0, hexp[i]});
        end
        pix(1'b0, 9'd0);
        repeat (4) cyc();

        // Rectangle x 10..19, y 5..9 in a 64x48 frame.
        h_min = 9'd100; h_max = 9'd140;
        vs_pulse(1'b1);
        check_box(0, 2, 0, 0, 3);
        frame(10, 19, 5, 9, -1, 9'd0, 9'd0);
        vs_pulse(1'b1);
        check_box(10, 19, 5, 9, 50);

        // Reset mid-frame discards the partial frame.
        pix(1'b1, 9'd120);
        repeat (10) cyc();
        reset_n = 1'b0;
        #1;
        check_all_zero("midreset");
        repeat (2) cyc();
        reset_n = 1'b1;
        pix(1'b0, 9'd0);
        repeat (2) cyc();
        vs_pulse(1'b0);
        frame(20, 29, 30, 33, -1, 9'd0, 9'd0);
        vs_pulse(1'b1);
        check_box(20, 29, 30, 33, 40);

        // Frame with no match.
        frame(1, 0, 1, 0, -1, 9'd0, 9'd0);
        vs_pulse(1'b1);
        check_box(0, 0, 0, 0, 0);

        // Threshold change mid-frame applies only from the next frame.
        frame(10, 19, 5, 9, 2, 9'd200, 9'd250);
        vs_pulse(1'b1);
        check_box(10, 19, 5, 9, 50);
        frame(10, 19, 5, 9, -1, 9'd0, 9'd0);
        vs_pulse(1'b1);
        check_box(0, 0, 0, 0, 0);

        // Matched pixel coinciding with frame start counts at y=0.
        h_min = 9'd100; h_max = 9'd140;
        hsv_bus.hsv_vs = 1'b1;
        pix(1'b1, 9'd120);
        cyc();
        pix(1'b0, 9'd0);
        cyc();
        chk("coincide_valid", {31'd0, box_valid}, 32'd1);
        check_box(0, 0, 0, 0, 0);
        hsv_bus.hsv_vs = 1'b0;
        repeat (4) cyc();
        vs_pulse(1'b1);
        check_box(0, 0, 0, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
